// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU instruction/data masters, the memory port
// and mem_port_arbiter. The slave modport is the arbiter's view; the master
// modport is the view of the surrounding environment (CPU core + memory).
interface mem_port_arbiter_if;
    // Instruction-fetch master
    logic [63:0] iadr_i;
    logic [1:0]  isiz_i;
    logic        iack_o;
    logic [31:0] idat_o;
    // Data master
    logic [63:0] dadr_i;
    logic [63:0] ddat_i;
    logic        dwe_i;
    logic        dcyc_i;
    logic        dstb_i;
    logic [1:0]  dsiz_i;
    logic        dsigned_i;
    logic        dack_o;
    logic [63:0] ddat_o;
    // Shared memory port
    logic [63:0] m_adr_o;
    logic [63:0] m_dat_o;
    logic        m_we_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_signed_o;
    logic [1:0]  m_siz_o;
    logic [63:0] m_dat_i;
    logic        m_ack_i;

    modport slave (
        input  iadr_i, isiz_i,
        output iack_o, idat_o,
        input  dadr_i, ddat_i, dwe_i, dcyc_i, dstb_i, dsiz_i, dsigned_i,
        output dack_o, ddat_o,
        output m_adr_o, m_dat_o, m_we_o, m_cyc_o, m_stb_o, m_signed_o, m_siz_o,
        input  m_dat_i, m_ack_i
    );

    modport master (
        output iadr_i, isiz_i,
        input  iack_o, idat_o,
        output dadr_i, ddat_i, dwe_i, dcyc_i, dstb_i, dsiz_i, dsigned_i,
        input  dack_o, ddat_o,
        input  m_adr_o, m_dat_o, m_we_o, m_cyc_o, m_stb_o, m_signed_o, m_siz_o,
        output m_dat_i, m_ack_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter sharing one 64-bit memory port between the CPU
// instruction-fetch master (I) and data master (D).
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin resolution of
// simultaneous requests; otherwise D has fixed priority.
// The memory port is steered combinationally from the registered grant so a
// zero-wait slave completes in the first grant cycle; a master dropping its
// request abandons the cycle immediately.
module mem_port_arbiter (
    input logic                 clk_i,
    input logic                 reset_i,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    state_t state_r;
    state_t state_next_s;
    logic   last_d_r;       // 1'b1: D served most recently, 1'b0: I
    logic   last_d_next_s;
    logic   ireq_s;
    logic   dreq_s;

    assign ireq_s = |bus.isiz_i;
    assign dreq_s = bus.dcyc_i & bus.dstb_i;

    // Read data is passed straight through; masters qualify it with their ack.
    assign bus.idat_o = bus.m_dat_i[31:0];
    assign bus.ddat_o = bus.m_dat_i;

    // Grant state and last-served register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r  <= IDLE;
            last_d_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            last_d_r <= last_d_next_s;
        end
    end

    // Next grant: arbitrate in IDLE, leave a grant on ack or request drop.
    always_comb begin
        state_next_s  = state_r;
        last_d_next_s = last_d_r;
        case (state_r)
            IDLE: begin
                if (ireq_s && dreq_s) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    if (last_d_r) begin
                        state_next_s = GNT_I;
                    end else begin
                        state_next_s = GNT_D;
                    end
`else
                    state_next_s = GNT_D;
`endif
                end else if (ireq_s) begin
                    state_next_s = GNT_I;
                end else if (dreq_s) begin
                    state_next_s = GNT_D;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GNT_I: begin
                if (!ireq_s) begin
                    state_next_s = IDLE;        // abandoned, last unchanged
                end else if (bus.m_ack_i) begin
                    state_next_s  = IDLE;
                    last_d_next_s = 1'b0;
                end else begin
                    state_next_s = GNT_I;
                end
            end
            GNT_D: begin
                if (!dreq_s) begin
                    state_next_s = IDLE;        // abandoned, last unchanged
                end else if (bus.m_ack_i) begin
                    state_next_s  = IDLE;
                    last_d_next_s = 1'b1;
                end else begin
                    state_next_s = GNT_D;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Steer the granted master onto the memory port and route its ack back.
    always_comb begin
        bus.m_adr_o    = 64'h0;
        bus.m_dat_o    = 64'h0;
        bus.m_we_o     = 1'b0;
        bus.m_cyc_o    = 1'b0;
        bus.m_stb_o    = 1'b0;
        bus.m_signed_o = 1'b0;
        bus.m_siz_o    = 2'b00;
        bus.iack_o     = 1'b0;
        bus.dack_o     = 1'b0;
        case (state_r)
            GNT_I: begin
                if (ireq_s) begin
                    bus.m_cyc_o = 1'b1;
                    bus.m_stb_o = 1'b1;
                    bus.m_adr_o = bus.iadr_i;
                    bus.m_siz_o = bus.isiz_i;
                    bus.iack_o  = bus.m_ack_i;
                end else begin
                    bus.m_cyc_o = 1'b0;
                end
            end
            GNT_D: begin
                if (dreq_s) begin
                    bus.m_cyc_o    = 1'b1;
                    bus.m_stb_o    = 1'b1;
                    bus.m_adr_o    = bus.dadr_i;
                    bus.m_dat_o    = bus.ddat_i;
                    bus.m_we_o     = bus.dwe_i;
                    bus.m_siz_o    = bus.dsiz_i;
                    bus.m_signed_o = bus.dsigned_i;
                    bus.dack_o     = bus.m_ack_i;
                end else begin
                    bus.m_cyc_o = 1'b0;
                end
            end
            default: begin
                bus.m_cyc_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Expectations are
// hand-computed; contention expectations follow MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] IADR = 64'h100;
    localparam logic [63:0] DADR = 64'h2000;

    logic [63:0] exp_adr [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.iadr_i    = IADR;
        bus.isiz_i    = 2'b10;
        bus.dadr_i    = 64'h3000;
        bus.ddat_i    = 64'h0;
        bus.dwe_i     = 1'b0;
        bus.dcyc_i    = 1'b1;
        bus.dstb_i    = 1'b1;
        bus.dsiz_i    = 2'b01;
        bus.dsigned_i = 1'b0;
        bus.m_dat_i   = 64'h0;
        bus.m_ack_i   = 1'b0;

        // Reset with both masters requesting: everything quiet.
        #2;
        check("rst_cyc", {63'h0, bus.m_cyc_o}, 64'h0);
        check("rst_stb", {63'h0, bus.m_stb_o}, 64'h0);
        check("rst_adr", bus.m_adr_o, 64'h0);
        check("rst_we",  {63'h0, bus.m_we_o}, 64'h0);
        check("rst_ack", {62'h0, bus.iack_o, bus.dack_o}, 64'h0);
        step();
        step();
        check("rst_hold_cyc", {63'h0, bus.m_cyc_o}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_idle", {63'h0, bus.m_cyc_o}, 64'h0);

        // First arbitration after reset: last = I so D wins in either build.
        step();
        check("first_gnt_cyc", {63'h0, bus.m_cyc_o}, 64'h1);
        check("first_gnt_adr", bus.m_adr_o, 64'h3000);
        bus.m_ack_i = 1'b1;
        #1;
        check("first_gnt_dack", {62'h0, bus.iack_o, bus.dack_o}, 64'h1);
        step();
        bus.m_ack_i = 1'b0;
        bus.isiz_i  = 2'b00;
        bus.dcyc_i  = 1'b0;
        bus.dstb_i  = 1'b0;
        #1;
        check("first_done_cyc", {63'h0, bus.m_cyc_o}, 64'h0);

        // Single fetch, slave acks two cycles after strobe rises.
        bus.isiz_i = 2'b10;
        bus.iadr_i = IADR;
        #1;
        check("fetch_latency", {63'h0, bus.m_stb_o}, 64'h0);
        step();
        check("fetch_stb", {63'h0, bus.m_stb_o}, 64'h1);
        check("fetch_adr", bus.m_adr_o, IADR);
        check("fetch_siz", {62'h0, bus.m_siz_o}, 64'h2);
        check("fetch_we",  {63'h0, bus.m_we_o}, 64'h0);
        check("fetch_dat", bus.m_dat_o, 64'h0);
        step();
        check("fetch_wait_iack", {63'h0, bus.iack_o}, 64'h0);
        step();
        bus.m_ack_i = 1'b1;
        bus.m_dat_i = 64'h0000_0000_0000_0013;
        #1;
        check("fetch_iack", {63'h0, bus.iack_o}, 64'h1);
        check("fetch_idat", {32'h0, bus.idat_o}, 64'h13);
        check("fetch_dack", {63'h0, bus.dack_o}, 64'h0);
        step();
        bus.m_ack_i = 1'b0;
        bus.isiz_i  = 2'b00;
        #1;
        check("fetch_end_iack", {63'h0, bus.iack_o}, 64'h0);
        check("fetch_end_cyc",  {63'h0, bus.m_cyc_o}, 64'h0);

        // D store with one wait state.
        bus.dadr_i    = DADR;
        bus.ddat_i    = 64'hDEAD_BEEF;
        bus.dwe_i     = 1'b1;
        bus.dsiz_i    = 2'b11;
        bus.dsigned_i = 1'b1;
        bus.dcyc_i    = 1'b1;
        bus.dstb_i    = 1'b1;
        step();
        check("store_adr", bus.m_adr_o, DADR);
        check("store_dat", bus.m_dat_o, 64'hDEAD_BEEF);
        check("store_siz", {62'h0, bus.m_siz_o}, 64'h3);
        check("store_we",  {63'h0, bus.m_we_o}, 64'h1);
        check("store_sgn", {63'h0, bus.m_signed_o}, 64'h1);
        step();
        check("store_wait_dack", {63'h0, bus.dack_o}, 64'h0);
        check("store_wait_we",   {63'h0, bus.m_we_o}, 64'h1);
        bus.m_ack_i = 1'b1;
        #1;
        check("store_dack", {62'h0, bus.iack_o, bus.dack_o}, 64'h1);
        step();
        bus.m_ack_i   = 1'b0;
        bus.dwe_i     = 1'b0;
        bus.dsigned_i = 1'b0;
        // Both keep requesting from here on; last = D now.
        bus.isiz_i = 2'b10;
        #1;
        check("store_end_dack", {63'h0, bus.dack_o}, 64'h0);

        // Contention with zero-wait slave, starting with last = D.
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_adr[0] = IADR; exp_adr[1] = DADR; exp_adr[2] = IADR; exp_adr[3] = DADR;
`else
        exp_adr[0] = DADR; exp_adr[1] = DADR; exp_adr[2] = DADR; exp_adr[3] = DADR;
`endif
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("cont%0d_adr", k), bus.m_adr_o, exp_adr[k]);
            bus.m_ack_i = 1'b1;
            #1;
            check($sformatf("cont%0d_ack", k), {62'h0, bus.iack_o, bus.dack_o},
                  (exp_adr[k] == IADR) ? 64'h2 : 64'h1);
            step();
            bus.m_ack_i = 1'b0;
            #1;
            check($sformatf("cont%0d_turn", k), {63'h0, bus.m_cyc_o}, 64'h0);
        end

        // Abort: D alone granted, drops during wait while I becomes pending.
        bus.isiz_i = 2'b00;
        step();
        check("abort_gnt_adr", bus.m_adr_o, DADR);
        step();
        bus.dcyc_i  = 1'b0;
        bus.isiz_i  = 2'b10;
        bus.m_ack_i = 1'b1;
        #1;
        check("abort_cyc",  {63'h0, bus.m_cyc_o}, 64'h0);
        check("abort_ack",  {62'h0, bus.iack_o, bus.dack_o}, 64'h0);
        step();
        bus.m_ack_i = 1'b0;
        #1;
        check("abort_idle", {63'h0, bus.m_cyc_o}, 64'h0);
        step();
        check("abort_i_adr", bus.m_adr_o, IADR);
        bus.m_ack_i = 1'b1;
        #1;
        check("abort_i_iack", {63'h0, bus.iack_o}, 64'h1);
        step();
        bus.m_ack_i = 1'b0;
        bus.isiz_i  = 2'b00;
        bus.dcyc_i  = 1'b1;

        // Async reset in the middle of a D wait state.
        step();
        check("areset_gnt_cyc", {63'h0, bus.m_cyc_o}, 64'h1);
        step();
        #2;
        rst = 1'b1;
        #1;
        check("areset_cyc", {63'h0, bus.m_cyc_o}, 64'h0);
        check("areset_stb", {63'h0, bus.m_stb_o}, 64'h0);
        bus.m_ack_i = 1'b1;
        #1;
        check("areset_dack", {63'h0, bus.dack_o}, 64'h0);
        step();
        #1;
        rst = 1'b0;
        #1;
        check("areset_late_dack", {63'h0, bus.dack_o}, 64'h0);
        bus.m_ack_i = 1'b0;
        bus.dcyc_i  = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
